rob_ctrl: RTL and testbench

//  Sequencer for the reorder buffer (ROB). Owns head/tail pointers and occupancy, grants in-order

---
 rtl/rob_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rob_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer sequencer.
//   Owns head/tail/count. Grants in-order allocation and retires the head entry in order.
//   An EXCEPTION at the head starts a one-cycle FLUSH that empties the buffer and redirects fetch.
// Optional feature macro: ROB_CTRL_STATS_EN adds the stat_commits and stat_full_stalls counters.
// Shared width/encoding macros get defaults here when the including build does not supply them.

`ifndef ROB_WIDTH
`define ROB_WIDTH 3
`endif
`ifndef ROB_STATE_WIDTH
`define ROB_STATE_WIDTH 2
`endif
`ifndef ROB_STATE_EMPTY
`define ROB_STATE_EMPTY 2'd0
`endif
`ifndef ROB_STATE_BUSY
`define ROB_STATE_BUSY 2'd1
`endif
`ifndef ROB_STATE_COMPLETE
`define ROB_STATE_COMPLETE 2'd2
`endif
`ifndef ROB_STATE_EXCEPTION
`define ROB_STATE_EXCEPTION 2'd3
`endif
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 6
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef VIRTUAL_ADDR_WIDTH
`define VIRTUAL_ADDR_WIDTH 32
`endif

module rob_ctrl (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            alloc_req,
    output logic                            alloc_grant,
    output logic [`ROB_WIDTH-1:0]           alloc_tag,
    output logic [`ROB_WIDTH-1:0]           head,
    output logic [`ROB_WIDTH-1:0]           tail,
    output logic [`ROB_WIDTH-1:0]           tag_read,
    input  logic [`ROB_STATE_WIDTH-1:0]     state_read,
    input  logic [`PHYSICAL_ADDR_WIDTH-1:0] addr_read,
    input  logic [`DATA_SIZE-1:0]           value_read,
    input  logic [`VIRTUAL_ADDR_WIDTH-1:0]  pc_read,
    output logic                            commit_en,
    output logic [`PHYSICAL_ADDR_WIDTH-1:0] commit_addr,
    output logic [`DATA_SIZE-1:0]           commit_value,
    output logic                            flush,
    output logic [`VIRTUAL_ADDR_WIDTH-1:0]  redirect_pc,
    output logic [`ROB_WIDTH:0]             count
`ifdef ROB_CTRL_STATS_EN
    ,
    output logic [31:0]                     stat_commits,
    output logic [31:0]                     stat_full_stalls
`endif
);

    // Count value meaning "every slot occupied" (ROB_ENTRIES = 2**ROB_WIDTH).
    localparam logic [`ROB_WIDTH:0] FULL_COUNT = {1'b1, {`ROB_WIDTH{1'b0}}};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic rob_full;
    logic rob_empty;
    logic do_commit;
    logic do_except;
    logic in_flush;

    assign rob_full  = (count == FULL_COUNT);
    assign rob_empty = (count == '0);
    assign in_flush  = (state == ST_FLUSH);

    // Allocation looks only at the current count, so a same-cycle commit never frees a slot early.
    assign alloc_grant = alloc_req & ~rob_full & (state == ST_RUN);
    assign alloc_tag   = tail;
    assign tag_read    = head;

    // Head decisions; an empty buffer ignores whatever stale state the ROB presents.
    always_comb begin
        do_commit = 1'b0;
        do_except = 1'b0;
        if (state == ST_RUN && !rob_empty) begin
            do_commit = (state_read == `ROB_STATE_COMPLETE);
            do_except = (state_read == `ROB_STATE_EXCEPTION);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // FSM next state: an excepting head costs exactly one FLUSH cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (do_except) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Pointers and occupancy; FLUSH discards every entry by pulling tail back to head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (in_flush) begin
            tail  <= head;
            count <= '0;
        end else begin
            if (alloc_grant) tail <= tail + 1'b1;
            if (do_commit)   head <= head + 1'b1;
            case ({alloc_grant, do_commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered retire and flush pulses plus their payloads (payloads hold between pulses).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_en    <= 1'b0;
            commit_addr  <= '0;
            commit_value <= '0;
            flush        <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            commit_en <= do_commit;
            flush     <= in_flush;
            if (do_commit) begin
                commit_addr  <= addr_read;
                commit_value <= value_read;
            end
            if (do_except) redirect_pc <= pc_read;
        end
    end

`ifdef ROB_CTRL_STATS_EN
    // Retired-instruction and full-buffer stall counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_commits     <= '0;
            stat_full_stalls <= '0;
        end else begin
            if (do_commit)             stat_commits     <= stat_commits + 32'd1;
            if (alloc_req && rob_full) stat_full_stalls <= stat_full_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl with a scoreboard: expected commits/flushes are queued by the
// stimulus and consumed by a separate negedge monitor. Build with ROB_CTRL_STATS_EN for stats.

`ifndef ROB_WIDTH
`define ROB_WIDTH 3
`endif
`ifndef ROB_STATE_WIDTH
`define ROB_STATE_WIDTH 2
`endif
`ifndef ROB_STATE_EMPTY
`define ROB_STATE_EMPTY 2'd0
`endif
`ifndef ROB_STATE_BUSY
`define ROB_STATE_BUSY 2'd1
`endif
`ifndef ROB_STATE_COMPLETE
`define ROB_STATE_COMPLETE 2'd2
`endif
`ifndef ROB_STATE_EXCEPTION
`define ROB_STATE_EXCEPTION 2'd3
`endif
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 6
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef VIRTUAL_ADDR_WIDTH
`define VIRTUAL_ADDR_WIDTH 32
`endif

module tb_rob_ctrl;

    localparam int N = 2 ** `ROB_WIDTH;

    logic                            clk = 1'b0;
    logic                            reset;
    logic                            alloc_req;
    logic                            alloc_grant;
    logic [`ROB_WIDTH-1:0]           alloc_tag, head, tail, tag_read;
    logic [`ROB_STATE_WIDTH-1:0]     state_read;
    logic [`PHYSICAL_ADDR_WIDTH-1:0] addr_read, commit_addr;
    logic [`DATA_SIZE-1:0]           value_read, commit_value;
    logic [`VIRTUAL_ADDR_WIDTH-1:0]  pc_read, redirect_pc;
    logic                            commit_en, flush;
    logic [`ROB_WIDTH:0]             count;
`ifdef ROB_CTRL_STATS_EN
    logic [31:0]                     stat_commits, stat_full_stalls;
`endif

    // Behavioural ROB storage read at tag_read.
    logic [`ROB_STATE_WIDTH-1:0]     rob_state [N];
    logic [`PHYSICAL_ADDR_WIDTH-1:0] rob_addr  [N];
    logic [`DATA_SIZE-1:0]           rob_val   [N];
    logic [`VIRTUAL_ADDR_WIDTH-1:0]  rob_pc    [N];

    assign state_read = rob_state[tag_read];
    assign addr_read  = rob_addr[tag_read];
    assign value_read = rob_val[tag_read];
    assign pc_read    = rob_pc[tag_read];

    typedef struct packed {
        logic [`PHYSICAL_ADDR_WIDTH-1:0] addr;
        logic [`DATA_SIZE-1:0]           val;
    } cexp_t;

    cexp_t                          cq[$];
    logic [`VIRTUAL_ADDR_WIDTH-1:0] fq[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rob_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_grant  (alloc_grant),
        .alloc_tag    (alloc_tag),
        .head         (head),
        .tail         (tail),
        .tag_read     (tag_read),
        .state_read   (state_read),
        .addr_read    (addr_read),
        .value_read   (value_read),
        .pc_read      (pc_read),
        .commit_en    (commit_en),
        .commit_addr  (commit_addr),
        .commit_value (commit_value),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .count        (count)
`ifdef ROB_CTRL_STATS_EN
        ,
        .stat_commits     (stat_commits),
        .stat_full_stalls (stat_full_stalls)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_one(input int exp_tag);
        alloc_req = 1'b1;
        #1;
        check("alloc_grant", 64'(alloc_grant), 64'd1);
        check("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
        tick();
        alloc_req = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a commit or flush pulse.
    always @(negedge clk) begin
        if (!reset) begin
            check("commit_flush_exclusive", 64'(commit_en & flush), 64'd0);
            if (commit_en) begin
                check("commit_expected", 64'(cq.size() != 0), 64'd1);
                if (cq.size() != 0) begin
                    cexp_t e;
                    e = cq.pop_front();
                    check("commit_addr", 64'(commit_addr), 64'(e.addr));
                    check("commit_value", 64'(commit_value), 64'(e.val));
                end
            end
            if (flush) begin
                check("flush_expected", 64'(fq.size() != 0), 64'd1);
                if (fq.size() != 0) begin
                    logic [`VIRTUAL_ADDR_WIDTH-1:0] p;
                    p = fq.pop_front();
                    check("redirect_pc", 64'(redirect_pc), 64'(p));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rob_state[i] = `ROB_STATE_BUSY;
            rob_addr[i]  = `PHYSICAL_ADDR_WIDTH'(8 + i);
            rob_val[i]   = `DATA_SIZE'(32'hC0DE0000 | i);
            rob_pc[i]    = `VIRTUAL_ADDR_WIDTH'(32'h100 + 4 * i);
        end
        reset     = 1'b1;
        alloc_req = 1'b0;
        #12;
        check("por_head", 64'(head), 64'd0);
        check("por_count", 64'(count), 64'd0);
        reset = 1'b0;
        tick();

        // Fill: tags 0..7, then the full buffer refuses a ninth request.
        for (int i = 0; i < N; i++) alloc_one(i);
        check("fill_count", 64'(count), 64'd8);
        check("fill_tail_wrap", 64'(tail), 64'd0);
        check("fill_head", 64'(head), 64'd0);
        alloc_req = 1'b1;
        #1;
        check("full_no_grant", 64'(alloc_grant), 64'd0);
        tick();
        tick();
        alloc_req = 1'b0;
        check("full_count_hold", 64'(count), 64'd8);
        check("full_tail_hold", 64'(tail), 64'd0);

        // Retire three entries back to back, then stall on BUSY entry 3.
        cq.push_back('{addr: 6'd8,  val: 32'hC0DE0000});
        cq.push_back('{addr: 6'd9,  val: 32'hC0DE0001});
        cq.push_back('{addr: 6'd10, val: 32'hC0DE0002});
        rob_state[0] = `ROB_STATE_COMPLETE;
        rob_state[1] = `ROB_STATE_COMPLETE;
        rob_state[2] = `ROB_STATE_COMPLETE;
        tick();
        tick();
        tick();
        check("c3_head", 64'(head), 64'd3);
        check("c3_count", 64'(count), 64'd5);
        tick();
        check("c3_head_stall", 64'(head), 64'd3);
        check("c3_no_commit", 64'(commit_en), 64'd0);
`ifdef ROB_CTRL_STATS_EN
        check("stat_commits", 64'(stat_commits), 64'd3);
        check("stat_full_stalls", 64'(stat_full_stalls), 64'd2);
`endif

        // Asynchronous reset in the middle of a cycle.
        #2;
        reset = 1'b1;
        #1;
        check("rst_head", 64'(head), 64'd0);
        check("rst_tail", 64'(tail), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_commit_en", 64'(commit_en), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
`ifdef ROB_CTRL_STATS_EN
        check("rst_stat_commits", 64'(stat_commits), 64'd0);
`endif
        for (int i = 0; i < N; i++) rob_state[i] = `ROB_STATE_BUSY;
        #3;
        reset = 1'b0;
        tick();

        // In-order commit: entry 1 completes first but must wait for entry 0.
        for (int i = 0; i < 3; i++) alloc_one(i);
        check("io_count", 64'(count), 64'd3);
        rob_state[1] = `ROB_STATE_COMPLETE;
        tick();
        tick();
        check("io_wait_head", 64'(head), 64'd0);
        check("io_wait_count", 64'(count), 64'd3);
        cq.push_back('{addr: 6'd8, val: 32'hC0DE0000});
        cq.push_back('{addr: 6'd9, val: 32'hC0DE0001});
        rob_state[0] = `ROB_STATE_COMPLETE;
        tick();
        check("io_commit0", 64'(commit_en), 64'd1);
        check("io_commit0_addr", 64'(commit_addr), 64'd8);
        check("io_head1", 64'(head), 64'd1);
        tick();
        check("io_commit1", 64'(commit_en), 64'd1);
        check("io_commit1_addr", 64'(commit_addr), 64'd9);
        check("io_head2", 64'(head), 64'd2);
        tick();
        check("io_stall", 64'(commit_en), 64'd0);
        check("io_stall_head", 64'(head), 64'd2);
        check("io_stall_count", 64'(count), 64'd1);

        // Simultaneous grant and commit at count 4.
        for (int i = 3; i < 6; i++) alloc_one(i);
        check("sim_count_before", 64'(count), 64'd4);
        cq.push_back('{addr: 6'd10, val: 32'hC0DE0002});
        rob_state[2] = `ROB_STATE_COMPLETE;
        alloc_one(6);
        check("sim_count", 64'(count), 64'd4);
        check("sim_head", 64'(head), 64'd3);
        check("sim_tail", 64'(tail), 64'd7);

        // Exception at head 3 with five entries live.
        alloc_one(7);
        check("exc_count_before", 64'(count), 64'd5);
        rob_pc[3]    = 32'h40;
        rob_state[3] = `ROB_STATE_EXCEPTION;
        fq.push_back(32'h40);
        tick();
        check("exc_no_commit", 64'(commit_en), 64'd0);
        check("exc_redirect_early", 64'(redirect_pc), 64'h40);
        alloc_req = 1'b1;
        #1;
        check("exc_flush_no_grant", 64'(alloc_grant), 64'd0);
        tick();
        alloc_req = 1'b0;
        check("exc_flush_pulse", 64'(flush), 64'd1);
        check("exc_redirect", 64'(redirect_pc), 64'h40);
        check("exc_count", 64'(count), 64'd0);
        check("exc_tail_eq_head", 64'(tail), 64'd3);
        check("exc_head", 64'(head), 64'd3);
        // Empty buffer must ignore a stale COMPLETE head.
        rob_state[3] = `ROB_STATE_COMPLETE;
        tick();
        check("exc_flush_done", 64'(flush), 64'd0);
        tick();
        check("empty_no_commit", 64'(commit_en), 64'd0);
        check("empty_head", 64'(head), 64'd3);
        check("empty_count", 64'(count), 64'd0);

        tick();
        check("commit_queue_drained", 64'(cq.size()), 64'd0);
        check("flush_queue_drained", 64'(fq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
